// File: rtl/seq_divider_control.sv
// Sequential restoring divider: Run loads the dividend and produces one quotient bit every SHIFT/TRIAL pair.
// Optional SIGNED_DIV_EN macro enables two's-complement operands with a FIX state for the result signs.
module seq_divider_control #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             Done,
  output logic             DivByZero,
  output logic [2:0]       o_dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_TRIAL = 3'd2,
    S_FIX   = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t           r_state;
  logic [WIDTH:0]   r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    r_cnt;
  logic             r_done;
  logic             r_dbz;

  logic [WIDTH-1:0] w_s_op;
  logic [WIDTH-1:0] w_b_op;
  logic [WIDTH:0]   w_diff;

`ifdef SIGNED_DIV_EN
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  logic r_sq;
  logic r_sr;
  // Magnitude of the most-negative value wraps to 2^(WIDTH-1), which is correct read as unsigned.
  assign w_s_op = S[WIDTH-1]   ? (~S + ONE)   : S;
  assign w_b_op = r_b[WIDTH-1] ? (~r_b + ONE) : r_b;
`else
  assign w_s_op = S;
  assign w_b_op = r_b;
`endif

  assign w_diff = r_a - {1'b0, w_b_op};

  assign Q           = r_q;
  assign R           = r_a[WIDTH-1:0];
  assign Done        = r_done;
  assign DivByZero   = r_dbz;
  assign o_dbg_state = r_state;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_q     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
`ifdef SIGNED_DIV_EN
      r_sq    <= 1'b0;
      r_sr    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Run) begin
            if (r_b != '0) begin
              r_q     <= w_s_op;
              r_a     <= '0;
              r_cnt   <= '0;
              r_dbz   <= 1'b0;
              r_state <= S_SHIFT;
`ifdef SIGNED_DIV_EN
              r_sq    <= S[WIDTH-1] ^ r_b[WIDTH-1];
              r_sr    <= S[WIDTH-1];
`endif
            end else begin
              r_q     <= '1;
              r_a     <= {1'b0, S};
              r_dbz   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_HALT;
            end
          end else if (ClearA_LoadB) begin
            r_b   <= S;
            r_a   <= '0;
            r_dbz <= 1'b0;
          end
        end
        S_SHIFT: begin
          {r_a, r_q} <= {r_a[WIDTH-1:0], r_q, 1'b0};
          r_state    <= S_TRIAL;
        end
        S_TRIAL: begin
          // A borrow out of the top bit means the trial subtraction failed: restore by not writing.
          if (!w_diff[WIDTH]) begin
            r_a    <= w_diff;
            r_q[0] <= 1'b1;
          end
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
`ifdef SIGNED_DIV_EN
            r_state <= S_FIX;
`else
            r_done  <= 1'b1;
            r_state <= S_HALT;
`endif
          end else begin
            r_state <= S_SHIFT;
          end
        end
`ifdef SIGNED_DIV_EN
        S_FIX: begin
          if (r_sq) r_q <= ~r_q + ONE;
          if (r_sr) r_a <= {1'b0, ~r_a[WIDTH-1:0] + ONE};
          r_done  <= 1'b1;
          r_state <= S_HALT;
        end
`endif
        S_HALT: begin
          if (!Run) begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_control.sv
// Bench for seq_divider_control: arithmetic reference model checked every cycle plus literal spot checks.
module tb_seq_divider_control;
  localparam int W = 8;
`ifdef SIGNED_DIV_EN
  localparam int EXP_LAT = 2 * W + 1;
`else
  localparam int EXP_LAT = 2 * W;
`endif

  logic         Clk = 1'b0;
  logic         Reset;
  logic         Run;
  logic         ClearA_LoadB;
  logic [W-1:0] S;
  logic [W-1:0] Q;
  logic [W-1:0] R;
  logic         Done;
  logic         DivByZero;
  logic [2:0]   o_dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  seq_divider_control #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .S(S),
    .Q(Q), .R(R), .Done(Done), .DivByZero(DivByZero), .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: 0 = idle, 1 = busy, 2 = halted. Results come straight from / and %.
  int           m_mode;
  int           m_left;
  logic [W-1:0] m_b, m_q, m_r;
  logic         m_dbz;
  int           sd, sb;

  always @(posedge Clk) begin
    if (Reset) begin
      m_mode = 0; m_left = 0; m_b = '0; m_q = '0; m_r = '0; m_dbz = 1'b0;
    end else begin
      case (m_mode)
        0: begin
          if (Run) begin
            if (m_b == '0) begin
              m_q = '1; m_r = S; m_dbz = 1'b1; m_mode = 2;
            end else begin
`ifdef SIGNED_DIV_EN
              sd = $signed(S); sb = $signed(m_b);
              m_q = W'(sd / sb); m_r = W'(sd % sb);
`else
              m_q = S / m_b; m_r = S % m_b;
`endif
              m_dbz = 1'b0; m_mode = 1; m_left = EXP_LAT;
            end
          end else if (ClearA_LoadB) begin
            m_b = S; m_r = '0; m_dbz = 1'b0;
          end
        end
        1: begin
          m_left--;
          if (m_left == 0) m_mode = 2;
        end
        default: if (!Run) m_mode = 0;
      endcase
    end
  end

  // Scoreboard compare, every cycle; Q/R are meaningful whenever the divider is not busy.
  always @(negedge Clk) begin
    if (chk_en && !Reset) begin
      chk("model_done", Done, (m_mode == 2));
      chk("model_dbz", DivByZero, m_dbz);
      if (m_mode != 1) begin
        chk("model_q", Q, m_q);
        chk("model_r", R, m_r);
      end
    end
  end

  // driver tasks
  task automatic do_load(input logic [W-1:0] v);
    @(negedge Clk); S = v; ClearA_LoadB = 1'b1;
    @(negedge Clk); ClearA_LoadB = 1'b0;
  endtask

  // Accepts at the next edge (edge 0); n returns the number of edges after edge 0 until Done.
  task automatic do_div(input logic [W-1:0] v, input bit with_load, output int n);
    bit seen;
    @(negedge Clk); S = v; Run = 1'b1; ClearA_LoadB = with_load;
    n = -1; seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge Clk);
      ClearA_LoadB = 1'b0;
      n++;
      if (Done) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++; n_errors++;
      $display("FAIL done_timeout: Done never rose within 60 cycles for S=0x%0h", v);
    end
  endtask

  task automatic do_release();
    @(negedge Clk); Run = 1'b0;
    @(negedge Clk);
    chk("release_done_low", Done, 0);
  endtask

  int n;

  initial begin
    Reset = 1'b1; Run = 1'b0; ClearA_LoadB = 1'b0; S = '0;
    @(posedge Clk); @(negedge Clk);
    chk_en = 1'b1;
    chk("reset_q", Q, 0); chk("reset_r", R, 0);
    chk("reset_done", Done, 0); chk("reset_dbz", DivByZero, 0);
    Reset = 1'b0;

    // 100 / 7
    do_load(8'd7);
    do_div(8'd100, 1'b0, n);
    chk("t1_latency", n, EXP_LAT);
    chk("t1_q", Q, 8'h0E); chk("t1_r", R, 8'h02);
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      chk("t4_hold_done", Done, 1); chk("t4_hold_q", Q, 8'h0E); chk("t4_hold_r", R, 8'h02);
    end
    do_release();
    do_div(8'd9, 1'b0, n);
    chk("t4_reuse_q", Q, 8'h01); chk("t4_reuse_r", R, 8'h02);
    do_release();

    // all-ones boundary and A<B path
    do_load(8'd1);
    do_div(8'hFF, 1'b0, n);
    chk("t2_ff_div1_q", Q, 8'hFF); chk("t2_ff_div1_r", R, 8'h00);
    do_release();
`ifndef SIGNED_DIV_EN
    do_load(8'hFF);
    do_div(8'hFE, 1'b0, n);
    chk("t2_fe_divff_q", Q, 8'h00); chk("t2_fe_divff_r", R, 8'hFE);
    do_release();
`endif

    // divide by zero
    do_load(8'd0);
    do_div(8'd42, 1'b0, n);
    chk("t3_dbz_latency", n, 0);
    chk("t3_dbz_flag", DivByZero, 1); chk("t3_dbz_q", Q, 8'hFF); chk("t3_dbz_r", R, 8'd42);
    do_release();
    chk("t3_dbz_sticky", DivByZero, 1);
    do_load(8'd3);
    chk("t3_dbz_cleared", DivByZero, 0);

    // reset mid-division
    do_load(8'd7);
    @(negedge Clk); S = 8'd100; Run = 1'b1;
    repeat (5) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk); Reset = 1'b0; Run = 1'b0;
    chk("t5_rst_q", Q, 0); chk("t5_rst_r", R, 0); chk("t5_rst_done", Done, 0);
    do_div(8'd5, 1'b0, n);
    chk("t5_rst_b_zero", DivByZero, 1);
    do_release();

    // Run and ClearA_LoadB together: the division wins, B stays 5
    do_load(8'd5);
    do_div(8'd23, 1'b1, n);
    chk("t5_both_q", Q, 8'd4); chk("t5_both_r", R, 8'd3);
    do_release();

`ifdef SIGNED_DIV_EN
    do_load(8'd7);
    do_div(8'h9C, 1'b0, n);
    chk("t6_neg_lat", n, 17);
    chk("t6_neg_q", Q, 8'hF2); chk("t6_neg_r", R, 8'hFE);
    do_release();
    do_load(8'hF9);
    do_div(8'd100, 1'b0, n);
    chk("t6_negdiv_q", Q, 8'hF2); chk("t6_negdiv_r", R, 8'h02);
    do_release();
    do_load(8'hFF);
    do_div(8'h80, 1'b0, n);
    chk("t6_wrap_q", Q, 8'h80); chk("t6_wrap_r", R, 8'h00); chk("t6_wrap_dbz", DivByZero, 0);
    do_release();
`endif

    // randomized divisions against the model
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) != 0)
        do_load(($urandom_range(0, 9) == 0) ? 8'd0 : W'($urandom));
      do_div(W'($urandom), ($urandom_range(0, 4) == 0), n);
      repeat ($urandom_range(0, 3)) @(negedge Clk);
      do_release();
      repeat ($urandom_range(0, 2)) @(negedge Clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
